// File: rtl/min_scan_scheduler.sv
// Round-robin shared minimum-search engine: snapshots one requester's vector and scans it CHUNK channels per cycle.
// Optional early exit on a zero minimum is enabled by defining MIN_SCAN_EARLY_EXIT_EN.
module min_scan_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int TOTAL_CHANNELS = 20,
    parameter int CHUNK          = 8,
    parameter int NUM_REQ        = 3,
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int IDX_W = (TOTAL_CHANNELS > 1) ? $clog2(TOTAL_CHANNELS) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*TOTAL_CHANNELS*DATA_WIDTH-1:0] req_values,
    input  logic [NUM_REQ*TOTAL_CHANNELS-1:0]          req_valids,
    output logic                                       rsp_valid,
    input  logic                                       rsp_ready,
    output logic [ID_W-1:0]                            rsp_id,
    output logic [DATA_WIDTH-1:0]                      rsp_min,
    output logic [IDX_W-1:0]                           rsp_index,
    output logic                                       rsp_found,
    output logic                                       busy
);

    localparam int NUM_CHUNKS = (TOTAL_CHANNELS + CHUNK - 1) / CHUNK;
    localparam int PADDED     = NUM_CHUNKS * CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LIDX_W     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]      r_chunk_cnt;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [DATA_WIDTH-1:0] r_run_min;
    logic [IDX_W-1:0]      r_run_index;
    logic                  r_run_found;

    logic [DATA_WIDTH-1:0] r_snap_val [NUM_CHUNKS][CHUNK];
    logic                  r_snap_vld [NUM_CHUNKS][CHUNK];

    logic [NUM_REQ-1:0]                   w_grant;
    logic [ID_W-1:0]                      w_grant_id;
    logic                                 w_grant_hit;
    logic                                 w_accept;
    logic [TOTAL_CHANNELS*DATA_WIDTH-1:0] w_sel_values;
    logic [TOTAL_CHANNELS-1:0]            w_sel_valids;
    logic [PADDED*DATA_WIDTH-1:0]         w_pad_values;
    logic [PADDED-1:0]                    w_pad_valids;
    logic [DATA_WIDTH-1:0]                w_chunk_min;
    logic [LIDX_W-1:0]                    w_chunk_lidx;
    logic                                 w_chunk_found;
    logic                                 w_merge;
    logic [IDX_W-1:0]                     w_global_idx;
    logic [DATA_WIDTH-1:0]                w_next_min;
    logic                                 w_next_found;
    logic                                 w_last;
    logic                                 w_finish;

    // Round-robin: first requester at or above rr_ptr, otherwise wrap to the lowest.
    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_hit = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!w_grant_hit && req_valid[r] && (r >= int'(r_rr_ptr))) begin
                w_grant_hit = 1'b1;
                w_grant[r]  = 1'b1;
                w_grant_id  = ID_W'(r);
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!w_grant_hit && req_valid[r]) begin
                w_grant_hit = 1'b1;
                w_grant[r]  = 1'b1;
                w_grant_id  = ID_W'(r);
            end
        end
    end

    assign req_ready = ((r_state == ST_IDLE) && !reset) ? w_grant : '0;
    assign w_accept  = |req_ready;

    always_comb begin
        w_sel_values = '0;
        w_sel_valids = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant_id == ID_W'(r)) begin
                w_sel_values = req_values[r*TOTAL_CHANNELS*DATA_WIDTH +: TOTAL_CHANNELS*DATA_WIDTH];
                w_sel_valids = req_valids[r*TOTAL_CHANNELS +: TOTAL_CHANNELS];
            end
        end
    end

    // Channels past TOTAL_CHANNELS in the last chunk carry zero data and are never valid.
    always_comb begin
        w_pad_values = '0;
        w_pad_valids = '0;
        w_pad_values[TOTAL_CHANNELS*DATA_WIDTH-1:0] = w_sel_values;
        w_pad_valids[TOTAL_CHANNELS-1:0]            = w_sel_valids;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < NUM_CHUNKS; c++) begin
                for (int j = 0; j < CHUNK; j++) begin
                    r_snap_val[c][j] <= w_pad_values[(c*CHUNK+j)*DATA_WIDTH +: DATA_WIDTH];
                    r_snap_vld[c][j] <= w_pad_valids[c*CHUNK+j];
                end
            end
        end
    end

    // Strict less-than keeps the lowest index among equal values inside the chunk.
    always_comb begin
        w_chunk_min   = '1;
        w_chunk_lidx  = '0;
        w_chunk_found = 1'b0;
        for (int j = 0; j < CHUNK; j++) begin
            if (r_snap_vld[r_chunk_cnt][j] &&
                (!w_chunk_found || (r_snap_val[r_chunk_cnt][j] < w_chunk_min))) begin
                w_chunk_found = 1'b1;
                w_chunk_min   = r_snap_val[r_chunk_cnt][j];
                w_chunk_lidx  = LIDX_W'(j);
            end
        end
    end

    assign w_merge      = w_chunk_found && (!r_run_found || (w_chunk_min < r_run_min));
    assign w_global_idx = IDX_W'(int'(r_chunk_cnt) * CHUNK + int'(w_chunk_lidx));
    assign w_next_min   = w_merge ? w_chunk_min : r_run_min;
    assign w_next_found = w_merge | r_run_found;
    assign w_last       = (r_chunk_cnt == CNT_W'(NUM_CHUNKS - 1));

`ifdef MIN_SCAN_EARLY_EXIT_EN
    assign w_finish = w_last || (w_next_found && (w_next_min == '0));
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_chunk_cnt <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_run_min   <= '1;
            r_run_index <= '0;
            r_run_found <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SCAN;
                        r_rsp_id    <= w_grant_id;
                        r_chunk_cnt <= '0;
                        r_run_min   <= '1;
                        r_run_index <= '0;
                        r_run_found <= 1'b0;
                        if (w_grant_id == ID_W'(NUM_REQ - 1))
                            r_rr_ptr <= '0;
                        else
                            r_rr_ptr <= w_grant_id + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_merge) begin
                        r_run_min   <= w_chunk_min;
                        r_run_index <= w_global_idx;
                        r_run_found <= 1'b1;
                    end
                    r_chunk_cnt <= r_chunk_cnt + 1'b1;
                    if (w_finish) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_min   = r_run_min;
    assign rsp_index = r_run_index;
    assign rsp_found = r_run_found;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_min_scan_scheduler.sv
// Directed bench for min_scan_scheduler: arbitration order, min/index results, ties, latency, hold and reset.
module tb_min_scan_scheduler;

    localparam int DW = 8;
    localparam int TC = 20;
    localparam int NR = 3;

`ifdef MIN_SCAN_EARLY_EXIT_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*TC*DW-1:0] req_values;
    logic [NR*TC-1:0]  req_valids;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_min;
    logic [4:0]        rsp_index;
    logic              rsp_found;
    logic              busy;

    logic [DW-1:0] tv   [NR][TC];
    logic          tvld [NR][TC];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    min_scan_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_values (req_values),
        .req_valids (req_valids),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_min    (rsp_min),
        .rsp_index  (rsp_index),
        .rsp_found  (rsp_found),
        .busy       (busy)
    );

    always_comb begin
        req_values = '0;
        req_valids = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < TC; c++) begin
                req_values[(r*TC+c)*DW +: DW] = tv[r][c];
                req_valids[r*TC+c]            = tvld[r][c];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int r, input logic [DW-1:0] v, input logic vd);
        for (int c = 0; c < TC; c++) begin
            tv[r][c]   = v;
            tvld[r][c] = vd;
        end
    endtask

    // Called at a negedge with req_valid already driven; returns at a negedge after the handshake.
    task automatic serve(input string tag, input int exp_id, input int exp_min, input int exp_idx,
                         input bit exp_found, input int exp_lat, input int hold, input bit drop_req);
        int lat;
        logic [NR-1:0] oh;
        oh = 3'b001 << exp_id;
        #1 chk({tag, ".grant"}, 32'(req_ready), 32'(oh));
        @(posedge clk);
        @(negedge clk);
        if (drop_req) req_valid = '0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, ".min"}, 32'(rsp_min), 32'(exp_min));
        chk({tag, ".index"}, 32'(rsp_index), 32'(exp_idx));
        chk({tag, ".found"}, 32'(rsp_found), 32'(exp_found));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_min"}, 32'(rsp_min), 32'(exp_min));
            chk({tag, ".hold_index"}, 32'(rsp_index), 32'(exp_idx));
            chk({tag, ".hold_id"}, 32'(rsp_id), 32'(exp_id));
            chk({tag, ".hold_noready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".rsp_cleared"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_req(input string tag, input int r, input int exp_min, input int exp_idx,
                          input bit exp_found, input int exp_lat);
        req_valid = 3'b001 << r;
        serve(tag, r, exp_min, exp_idx, exp_found, exp_lat, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 3'b111;
        rsp_ready = 1'b0;
        for (int r = 0; r < NR; r++) fill(r, 8'd50, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_min", 32'(rsp_min), 32'hFF);
        chk("reset.rsp_index", 32'(rsp_index), 32'd0);
        chk("reset.rsp_found", 32'(rsp_found), 32'd0);
        chk("reset.rsp_id", 32'(rsp_id), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);

        // Three requesters asserting continuously: grants 0,1,2,0; first response held 5 cycles.
        tv[0][5]  = 8'd9;
        tv[1][17] = 8'd3;
        tv[2][0]  = 8'd1;
        reset     = 1'b0;
        req_valid = 3'b111;
        serve("rr0", 0, 9, 5, 1'b1, 4, 5, 1'b0);
        serve("rr1", 1, 3, 17, 1'b1, 4, 0, 1'b0);
        serve("rr2", 2, 1, 0, 1'b1, 4, 0, 1'b0);
        serve("rr3", 0, 9, 5, 1'b1, 4, 0, 1'b0);
        req_valid = '0;

        // Reset during the second SCAN cycle discards the request.
        fill(2, 8'd60, 1'b1);
        tv[2][7]  = 8'd2;
        req_valid = 3'b100;
        #1 chk("rst_mid.grant", 32'(req_ready), 32'b100);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_mid.ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid.rsp_min", 32'(rsp_min), 32'hFF);
        chk("rst_mid.rsp_found", 32'(rsp_found), 32'd0);
        chk("rst_mid.rsp_index", 32'(rsp_index), 32'd0);
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rst_mid.no_resp", 32'(rsp_valid), 32'd0);
        tv[2][7]  = 8'd60;
        tv[2][19] = 8'd4;
        do_req("rst_after", 2, 4, 19, 1'b1, 4);

        // Values 20..39 with channel 13 = 5.
        for (int c = 0; c < TC; c++) begin
            tv[0][c]   = 8'(20 + c);
            tvld[0][c] = 1'b1;
        end
        tv[0][13] = 8'd5;
        do_req("single", 0, 5, 13, 1'b1, 4);

        fill(1, 8'd50, 1'b1);
        tv[1][3]  = 8'd7;
        tv[1][11] = 8'd7;
        do_req("tie_across", 1, 7, 3, 1'b1, 4);

        fill(2, 8'd50, 1'b1);
        tv[2][9]  = 8'd7;
        tv[2][10] = 8'd7;
        do_req("tie_inside", 2, 7, 9, 1'b1, 4);

        fill(0, 8'd0, 1'b0);
        do_req("none_valid", 0, 8'hFF, 0, 1'b0, 4);

        tv[0][18]   = 8'd12;
        tvld[0][18] = 1'b1;
        do_req("last_chunk", 0, 12, 18, 1'b1, 4);

        fill(1, 8'd50, 1'b1);
        tv[1][2] = 8'd0;
        do_req("zero_min", 1, 0, 2, 1'b1, ZERO_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
